// File: rtl/rv32i_pkg.sv
// Purpose : shared types and constants for the instruction-fetch front end.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: fetch_state_e FSM encoding, IM_ARPROT constant, default reset vector.
package rv32i_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ADDR = 1'b1
    } fetch_state_e;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0]  IM_ARPROT            = 3'b100;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_credit_counter.sv
// Purpose : saturating up/down counter of in-flight AR requests, with credit output.
// Latency : count registered; o_has_credit is combinational on this cycle's inc/dec.
// Backpr. : o_has_credit low once the post-update count reaches MAX_COUNT.
// Ports   : clk, rstn (sync, active-low), i_inc (AR handshake), i_dec (R handshake),
//           o_count (registered count), o_has_credit (count after this cycle < MAX_COUNT).
module fetch_credit_counter #(
    parameter  int unsigned MAX_COUNT = 4,
    localparam int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_has_credit
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_dec_ok;
    logic          w_inc_ok;

    // A decrement with nothing outstanding is dropped rather than wrapping.
    assign w_dec_ok = i_dec && (r_count != '0);
    // Saturate at MAX_COUNT unless a decrement frees a slot in the same cycle.
    assign w_inc_ok = i_inc && ((r_count != CW'(MAX_COUNT)) || w_dec_ok);

    always_comb begin
        w_count_next = r_count;
        if (w_inc_ok && !w_dec_ok) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_inc_ok && w_dec_ok) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Credit is judged on the count as it will stand after this cycle, which
    // covers both the idle case and the back-to-back case after an increment.
    assign o_has_credit = (w_count_next < CW'(MAX_COUNT));
    assign o_count      = r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(i_dec && (r_count == '0)))
                else $error("fetch_credit_counter: R handshake with nothing outstanding");
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch; owns the PC, issues epoch-tagged AXI-Lite AR requests.
// Latency : first arvalid one cycle after reset release; redirect target on AR next cycle.
// Backpr. : holds AR payload until arready; stops issuing on i_stall or no credit.
// Ports   : clk/rstn (sync, active-low); AR channel o_im_bus_ar*/i_im_bus_arready;
//           observed R handshake i_im_bus_rvalid/rready; i_stall; i_redirect_valid/pc;
//           o_epoch, o_outstanding; o_misaligned_fault only with FETCH_ALIGN_CHECK_EN.
// Option  : FETCH_ALIGN_CHECK_EN - misaligned redirect raises a fault and parks fetch
//           until the next aligned redirect; otherwise the low PC bits are dropped.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter  int unsigned     XLEN            = 32,
    parameter  logic [XLEN-1:0] RESET_VECTOR    = XLEN'(DEFAULT_RESET_VECTOR),
    parameter  int unsigned     MAX_OUTSTANDING = 4,
    parameter  int unsigned     IDLEN           = 4,
    localparam int unsigned     CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             o_im_bus_arvalid,
    input  logic             i_im_bus_arready,
    output logic [XLEN-1:0]  o_im_bus_araddr,
    output logic [2:0]       o_im_bus_arprot,
    output logic [IDLEN-1:0] o_im_bus_arid,
    input  logic             i_im_bus_rvalid,
    input  logic             i_im_bus_rready,
    input  logic             i_stall,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_pc,
    output logic [IDLEN-1:0] o_epoch,
    output logic [CW-1:0]    o_outstanding
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic             o_misaligned_fault
`endif
);

    fetch_state_e     r_state;
    logic             r_arvalid;
    logic [XLEN-1:0]  r_araddr;
    logic [IDLEN-1:0] r_arid;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [IDLEN-1:0] r_epoch;
    logic             r_redirect_pending;

    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_has_credit;
    logic [XLEN-1:0]  w_redirect_tgt;
    logic [XLEN-1:0]  w_pc_next;
    logic [IDLEN-1:0] w_epoch_next;
    logic             w_fault_next;
    logic             w_issue;

    assign w_ar_hs        = r_arvalid && i_im_bus_arready;
    assign w_r_hs         = i_im_bus_rvalid && i_im_bus_rready;
    assign w_redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
    assign w_fault_next       = i_redirect_valid ? (i_redirect_pc[1:0] != 2'b00) : r_fault;
    assign o_misaligned_fault = r_fault;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_next;
        end
    end
`else
    logic w_unused_pc_low;
    assign w_fault_next    = 1'b0;
    assign w_unused_pc_low = ^i_redirect_pc[1:0];
`endif

    // The PC the next request should carry. While a redirect is pending the
    // in-flight request is stale, so its address must not advance the PC.
    always_comb begin
        w_pc_next = r_fetch_pc;
        if (i_redirect_valid) begin
            w_pc_next = w_redirect_tgt;
        end else if (w_ar_hs && !r_redirect_pending) begin
            w_pc_next = r_araddr + XLEN'(4);
        end
    end

    assign w_epoch_next = i_redirect_valid ? (r_epoch + IDLEN'(1)) : r_epoch;
    assign w_issue      = !i_stall && w_has_credit && !w_fault_next;

    fetch_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_credit (
        .clk          (clk),
        .rstn         (rstn),
        .i_inc        (w_ar_hs),
        .i_dec        (w_r_hs),
        .o_count      (o_outstanding),
        .o_has_credit (w_has_credit)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state            <= S_IDLE;
            r_arvalid          <= 1'b0;
            r_araddr           <= RESET_VECTOR;
            r_arid             <= '0;
            r_fetch_pc         <= RESET_VECTOR;
            r_epoch            <= '0;
            r_redirect_pending <= 1'b0;
        end else begin
            r_fetch_pc <= w_pc_next;
            r_epoch    <= w_epoch_next;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state   <= S_ADDR;
                        r_arvalid <= 1'b1;
                        r_araddr  <= w_pc_next;
                        r_arid    <= w_epoch_next;
                    end
                end
                S_ADDR: begin
                    if (w_ar_hs) begin
                        r_redirect_pending <= 1'b0;
                        if (w_issue) begin
                            r_araddr <= w_pc_next;
                            r_arid   <= w_epoch_next;
                        end else begin
                            r_state   <= S_IDLE;
                            r_arvalid <= 1'b0;
                        end
                    end else if (i_redirect_valid) begin
                        // Payload stays frozen; the stale beat is dropped by decode.
                        r_redirect_pending <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign o_im_bus_arvalid = r_arvalid;
    assign o_im_bus_araddr  = r_araddr;
    assign o_im_bus_arid    = r_arid;
    assign o_im_bus_arprot  = IM_ARPROT;
    assign o_epoch          = r_epoch;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : self-checking bench for fetch_unit: directed scenarios plus random traffic.
// Latency : n/a.
// Backpr. : randomises arready, stall and R handshakes against a transaction-level model.
module tb_fetch_unit;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        o_im_bus_arvalid;
    logic        i_im_bus_arready = 1'b0;
    logic [31:0] o_im_bus_araddr;
    logic [2:0]  o_im_bus_arprot;
    logic [3:0]  o_im_bus_arid;
    logic        i_im_bus_rvalid = 1'b0;
    logic        i_im_bus_rready = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [3:0]  o_epoch;
    logic [2:0]  o_outstanding;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        o_misaligned_fault;
`endif

    fetch_unit dut (
        .clk              (clk),
        .rstn             (rstn),
        .o_im_bus_arvalid (o_im_bus_arvalid),
        .i_im_bus_arready (i_im_bus_arready),
        .o_im_bus_araddr  (o_im_bus_araddr),
        .o_im_bus_arprot  (o_im_bus_arprot),
        .o_im_bus_arid    (o_im_bus_arid),
        .i_im_bus_rvalid  (i_im_bus_rvalid),
        .i_im_bus_rready  (i_im_bus_rready),
        .i_stall          (i_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_epoch          (o_epoch),
        .o_outstanding    (o_outstanding)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .o_misaligned_fault (o_misaligned_fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference: where the next request must point, which
    // epoch it carries, how many reads are in flight, and whether a request
    // should be on the bus.
    logic [31:0] m_pc;
    logic [3:0]  m_epoch;
    int          m_out;
    logic        m_vld;
    logic        m_new;
    logic        m_redir_since;
    logic        m_fault;
    logic [31:0] m_cur_addr;
    logic [3:0]  m_cur_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("arvalid", 32'(o_im_bus_arvalid), 32'(m_vld));
        if (m_vld) begin
            if (m_new) begin
                m_cur_addr = m_pc;
                m_cur_id   = m_epoch;
            end
            chk("araddr", o_im_bus_araddr, m_cur_addr);
            chk("arid", 32'(o_im_bus_arid), 32'(m_cur_id));
        end
        chk("epoch", 32'(o_epoch), 32'(m_epoch));
        chk("outstanding", 32'(o_outstanding), 32'(m_out));
        chk("arprot", 32'(o_im_bus_arprot), 32'h4);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("fault", 32'(o_misaligned_fault), 32'(m_fault));
`endif
    endtask

    // Called just after a falling edge: drive inputs, advance the model over
    // the next rising edge, then check at the following falling edge.
    task automatic step(input logic st, input logic ar, input logic rb,
                        input logic rd, input logic [31:0] rpc);
        logic hs;
        logic rbeat;
        int   rsel;
        rbeat = rb && (m_out > 0);
        rsel  = $urandom_range(0, 2);
        i_stall          = st;
        i_im_bus_arready = ar;
        i_im_bus_rvalid  = rbeat || (rsel == 1);
        i_im_bus_rready  = rbeat || (rsel == 2);
        i_redirect_valid = rd;
        i_redirect_pc    = rpc;

        hs = m_vld && ar;
        if (hs) begin
            if (!m_redir_since) m_pc = m_cur_addr + 32'd4;
            m_redir_since = 1'b0;
        end
        if (rd) begin
            if (m_vld && !hs) m_redir_since = 1'b1;
            m_pc    = {rpc[31:2], 2'b00};
            m_epoch = m_epoch + 4'd1;
`ifdef FETCH_ALIGN_CHECK_EN
            m_fault = (rpc[1:0] != 2'b00);
`endif
        end
        m_out = m_out + (hs ? 1 : 0) - (rbeat ? 1 : 0);
        if (m_vld && !hs) begin
            m_new = 1'b0;
        end else begin
            m_vld = !st && (m_out < MAX_OUT) && !m_fault;
            m_new = m_vld;
        end

        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn             = 1'b0;
        i_stall          = 1'b0;
        i_im_bus_arready = 1'b0;
        i_im_bus_rvalid  = 1'b0;
        i_im_bus_rready  = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        repeat (2) @(negedge clk);
        m_pc = 32'h0; m_epoch = 4'd0; m_out = 0; m_vld = 1'b0; m_new = 1'b0;
        m_redir_since = 1'b0; m_fault = 1'b0; m_cur_addr = 32'h0; m_cur_id = 4'd0;
        chk("rst_arvalid", 32'(o_im_bus_arvalid), 32'h0);
        chk("rst_araddr", o_im_bus_araddr, 32'h0);
        chk("rst_arid", 32'(o_im_bus_arid), 32'h0);
        chk("rst_epoch", 32'(o_epoch), 32'h0);
        chk("rst_outstanding", 32'(o_outstanding), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_fault", 32'(o_misaligned_fault), 32'h0);
`endif
        rstn = 1'b1;
    endtask

    initial begin
        // Streaming with one read returned per cycle: one request per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("stream_addr", o_im_bus_araddr, 32'h1C);
        chk("stream_outstanding", 32'(o_outstanding), 32'h1);

        // No reads returned: exactly MAX_OUT requests, then one freed slot.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("credit_full_vld", 32'(o_im_bus_arvalid), 32'h0);
        chk("credit_full_cnt", 32'(o_outstanding), 32'h4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("credit_resume_addr", o_im_bus_araddr, 32'h10);

        // Redirect while a request waits for arready: payload frozen.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("pend_addr", o_im_bus_araddr, 32'h8);
        chk("pend_id", 32'(o_im_bus_arid), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("pend_next_addr", o_im_bus_araddr, 32'h100);
        chk("pend_next_id", 32'(o_im_bus_arid), 32'h1);

        // Redirect in the same cycle as a handshake.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("coinc_addr", o_im_bus_araddr, 32'h200);
        chk("coinc_id", 32'(o_im_bus_arid), 32'h1);

        // Sixteen redirects wrap the epoch; stall does not withdraw arvalid.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i * 16));
        chk("epoch_wrap", 32'(o_epoch), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_hold_vld", 32'(o_im_bus_arvalid), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_drop_vld", 32'(o_im_bus_arvalid), 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect parks fetch until an aligned one arrives.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
        chk("mis_fault_set", 32'(o_misaligned_fault), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mis_parked", 32'(o_im_bus_arvalid), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        chk("mis_fault_clr", 32'(o_misaligned_fault), 32'h0);
        chk("mis_resume_addr", o_im_bus_araddr, 32'h300);
`endif

        // Random traffic, with one reset dropped in mid-stream.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0,
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode unit.
- Owns the program counter and drives the AXI5-Lite read-address (AR) channel to instruction memory.
- The R channel goes straight from memory to decode; this block only observes the R handshake to track outstanding reads.
- Tags every request with an epoch ID so decode can drop responses made stale by a jump or branch redirect.

Parameters:
- XLEN, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 4, maximum AR requests accepted without an R handshake; must be < 2**IDLEN.
- IDLEN, 4, width of arid and epoch.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- o_im_bus_arvalid  out  1  AR valid.
- i_im_bus_arready  in  1  AR ready.
- o_im_bus_araddr  out  XLEN  fetch address, word aligned.
- o_im_bus_arprot  out  3  constant 3'b100 (instruction, secure, unprivileged).
- o_im_bus_arid  out  IDLEN  epoch tag of the request.
- i_im_bus_rvalid  in  1  R valid, observed only.
- i_im_bus_rready  in  1  R ready from decode, observed only.
- i_stall  in  1  blocks new requests.
- i_redirect_valid  in  1  jump/branch taken, single-cycle pulse.
- i_redirect_pc  in  XLEN  redirect target.
- o_epoch  out  IDLEN  current epoch; decode discards R beats with rid != o_epoch.
- o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.

Behaviour:
- Clocking and reset
  - rstn is synchronous, active-low; clock is clk.
  - Reset values: arvalid=0, araddr=RESET_VECTOR, arid=0, epoch=0, outstanding=0, fetch_pc=RESET_VECTOR, redirect_pending=0, state=S_IDLE.
  - Reset mid-transaction abandons everything immediately; memory is reset by the same rstn.
- FSM states and transitions
  - S_IDLE: arvalid=0. Go to S_ADDR when !i_stall && credit, where credit = (outstanding < MAX_OUTSTANDING, or a decrement occurs this cycle). On that transition load araddr=fetch_pc (or i_redirect_pc if redirect this cycle) and arid=epoch (post-increment).
  - S_ADDR: arvalid=1; araddr and arid held stable until arready (AXI rule). i_stall does not withdraw a pending arvalid.
  - On handshake, if !i_stall && credit remains after the increment: stay in S_ADDR with the next payload (back-to-back, one request per cycle). Otherwise go to S_IDLE.
- arvalid is never a combinational function of arready.
- PC update
  - On handshake with no redirect this cycle and redirect_pending=0: fetch_pc <= araddr+4, wrapping modulo 2**XLEN.
  - On i_redirect_valid: fetch_pc <= {i_redirect_pc[XLEN-1:2],2'b00}; epoch <= epoch+1, wrapping at 2**IDLEN-1 -> 0.
  - Redirect in S_ADDR without handshake: set redirect_pending. The pending request keeps its old arid (stale). Clear redirect_pending on handshake.
  - Redirect coincident with handshake: the handshake completes with the old address/ID; the next request uses the target.
  - Back-to-back redirects: the last target wins; epoch increments once per pulse.
- Outstanding counter
  - +1 on AR handshake; -1 on i_im_bus_rvalid&&i_im_bus_rready; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - An R handshake at count 0 is ignored and flagged by a simulation assertion.
- Latency: redirect sampled at edge N -> arvalid with the target at edge N+1 if idle with credit. First arvalid appears one cycle after rstn deasserts.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: adds output o_misaligned_fault (1 bit, reset 0).
  - A redirect with i_redirect_pc[1:0]!=0 sets the fault, increments epoch, and parks the FSM in S_IDLE (after completing any pending AR handshake).
  - Cleared, and fetch resumes, on the next aligned redirect.
- Undefined: no port; low two bits are cleared silently.

Decomposition:
- Shared package rv32i_pkg: fetch_state_e {S_IDLE,S_ADDR}, IM_ARPROT=3'b100 constant, default RESET_VECTOR constant.
- One sub-module, fetch_credit_counter: parameterised up/down counter with saturation and underflow assertion; outputs count and has_credit.

Test Plan:
- Reset release, arready tied 1, rvalid&rready tied 1 -> araddr 0x0,0x4,0x8,... one per cycle; arid=0; outstanding stays 1.
- arready=1, no R beats, MAX_OUTSTANDING=4 -> exactly 4 handshakes (0x0..0xC), then arvalid=0; one R handshake -> next request at 0x10.
- arready=0 holding araddr=0x8; redirect to 0x100 -> araddr stays 0x8, arid=0 until handshake; next request 0x100 with arid=1; o_epoch=1.
- Redirect coincident with handshake at 0x4 -> 0x4 accepted with arid=0; next araddr=0x200, arid=1.
- 16 redirects with IDLEN=4 -> epoch wraps 15->0; i_stall=1 while arvalid=1 -> arvalid held until arready.
- FETCH_ALIGN_CHECK_EN defined: redirect to 0x102 -> o_misaligned_fault=1, no further arvalid; redirect to 0x300 -> fault clears, araddr=0x300.
